fazyrv_spm_d_seq: RTL
=====================

Name: fazyrv_spm_d_seq

Overview:
Sequencer for the data scratchpad (spm_d) in the FazyRV core.
- Accepts one load, store or shift instruction at a time.
- Drives the spm_d cycle qualifiers (ld_par, cyc_rd, cyc_wt, cyc_shft) and the chunk counter icyc.
- Runs the dmem strobe/ack handshake.
- Signals completion or a misalignment trap back to the core control.

Parameters:
- CHUNKSIZE, 2: datapath width in bits; legal values 1, 2, 4, 8.
- ICYC, 32/CHUNKSIZE: cycles per serial pass.
- TIMEOUT_CYC, 255: dmem ack timeout in cycles; used only with FAZYRV_SPMD_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- start_i  in  1  dispatch pulse; sampled only in IDLE
- instr_ld_i  in  1  load instruction
- instr_st_i  in  1  store instruction
- shft_op_i  in  1  shift instruction
- misalngd_i  in  1  from spm_d misalngd_o
- shft_done_i  in  1  from spm_d done_o
- dmem_stb_o  out  1  dmem request strobe
- dmem_we_o  out  1  dmem write enable
- dmem_ack_i  in  1  dmem acknowledge
- ld_par_o  out  1  to spm_d ld_par_i
- cyc_rd_o  out  1  to spm_d cyc_rd_i
- cyc_wt_o  out  1  to spm_d cyc_wt_i
- cyc_shft_o  out  1  to spm_d cyc_shft_i
- icyc_o  out  $clog2(ICYC)  chunk index
- icyc_lsb_o  out  1  icyc_o == 0 during a pass
- icyc_msb_o  out  1  icyc_o == ICYC-1 during a pass
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- trap_o  out  1  one-cycle misalignment (or timeout) pulse

Behaviour:
- Reset: state=IDLE, icyc=0. Every output is 0 while rst_in is low, including dmem_stb_o; it drops asynchronously on reset mid-operation. No pending request survives reset.
- States: IDLE, FILL, WAIT, SHFT, DRAIN.
- Opcode priority: ld > st > shft. A start with none of the three set is ignored.
- IDLE, start_i with ld or st and misalngd_i=1: trap_o pulses that cycle. No strobe is issued. Stay in IDLE.
- IDLE, start_i with st: go to FILL. Then FILL → WAIT → IDLE.
- IDLE, start_i with ld: go to WAIT. Then WAIT → SHFT → DRAIN → IDLE.
- IDLE, start_i with shft: go to FILL. Then FILL → SHFT → DRAIN → IDLE.
- FILL and DRAIN:
  - Exactly ICYC cycles each; icyc counts 0..ICYC-1 and wraps to 0 on exit.
  - cyc_rd_o=1 only in DRAIN.
  - icyc_lsb_o/icyc_msb_o are valid only in FILL/DRAIN and 0 elsewhere.
  - icyc_o holds 0 outside these states.
- WAIT:
  - dmem_stb_o=1 and cyc_wt_o=1. dmem_we_o = store.
  - Strobe is held until the cycle dmem_ack_i=1, then drops the next cycle.
  - On the ack cycle, for a load, ld_par_o=1 (combinational: WAIT & ld & ack).
  - A store pulses done_o on its ack cycle and returns to IDLE.
  - dmem_ack_i outside WAIT is ignored.
- SHFT:
  - cyc_shft_o=1. Minimum 1 cycle.
  - Exit to DRAIN on the first SHFT cycle in which shft_done_i=1.
  - A zero-step shift/aligned load therefore spends exactly 1 cycle in SHFT.
- DRAIN: done_o pulses on the icyc=ICYC-1 cycle.
- start_i while busy_o=1 is ignored; no queuing.
- All cyc_*/ld_par outputs are mutually exclusive, except that cyc_wt_o and ld_par_o coincide on the load ack cycle.
- Latency at CHUNKSIZE=2:
  - store: 16 + W cycles (W ≥ 1 wait cycles including ack).
  - load: W + S + 16 cycles (S = SHFT cycles).
  - shift: 16 + S + 16 cycles.

Optional Feature:
- Macro: FAZYRV_SPMD_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse without ack: dmem_stb_o drops, trap_o pulses one cycle, state returns to IDLE, done_o is not asserted.
  - A late ack is ignored.
- Undefined: no counter is instantiated; WAIT waits indefinitely.

Test Plan:
- Store, CHUNKSIZE=2, ack after 3 cycles: FILL is 16 cycles with icyc 0..15 and lsb@0/msb@15. Then stb=we=1 for 3 cycles, done_o on the ack cycle, busy_o=0 the next cycle.
- Load, ack on the 1st WAIT cycle, shft_done_i high immediately: ld_par_o=1 on the ack cycle. Then 1 SHFT cycle, 16 DRAIN cycles with cyc_rd_o=1, done_o at icyc=15. Total 18 cycles.
- Shift, shft_done_i rising after 5 SHFT cycles: 16 FILL + 5 SHFT + 16 DRAIN. cyc_shft_o=1 for exactly 5 cycles. No dmem_stb_o.
- Load with misalngd_i=1: trap_o pulses 1 cycle, dmem_stb_o never asserts, busy_o stays 0.
- rst_in low during WAIT and in mid-DRAIN (icyc=7): all outputs 0 asynchronously. After release, state is IDLE, icyc_o=0, and a new start_i is accepted.
- With FAZYRV_SPMD_TIMEOUT_EN and TIMEOUT_CYC=4, no ack: stb is high for 4 cycles, then trap_o pulses, done_o stays 0, and an ack one cycle later is ignored.

Source files
------------

// File: rtl/fazyrv_spm_d_seq.sv
// Sequencer for the FazyRV data scratchpad (spm_d).
// Accepts one load, store or shift at a time. It drives the spm_d cycle
// qualifiers and the chunk counter, runs the dmem strobe/ack handshake, and
// reports completion or a misalignment trap back to core control.
// Optional feature: define FAZYRV_SPMD_TIMEOUT_EN to abort a WAIT that sees
// no ack within TIMEOUT_CYC cycles. The abort raises a trap instead of done.
module fazyrv_spm_d_seq #(
  parameter int CHUNKSIZE   = 2,
  parameter int ICYC        = 32/CHUNKSIZE,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic                    start_i,
  input  logic                    instr_ld_i,
  input  logic                    instr_st_i,
  input  logic                    shft_op_i,
  input  logic                    misalngd_i,
  input  logic                    shft_done_i,
  output logic                    dmem_stb_o,
  output logic                    dmem_we_o,
  input  logic                    dmem_ack_i,
  output logic                    ld_par_o,
  output logic                    cyc_rd_o,
  output logic                    cyc_wt_o,
  output logic                    cyc_shft_o,
  output logic [$clog2(ICYC)-1:0] icyc_o,
  output logic                    icyc_lsb_o,
  output logic                    icyc_msb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    trap_o
);

  localparam int            IW        = $clog2(ICYC);
  localparam logic [IW-1:0] ICYC_LAST = IW'(ICYC-1);

  // Reject illegal configurations at elaboration.
  if (!(CHUNKSIZE == 1 || CHUNKSIZE == 2 || CHUNKSIZE == 4 || CHUNKSIZE == 8)) begin : g_bad_chunk
    $error("fazyrv_spm_d_seq: CHUNKSIZE must be 1, 2, 4 or 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("fazyrv_spm_d_seq: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, FILL, WAIT, SHFT, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] icyc;
  logic          op_ld, op_st;

  // Opcode priority: ld > st > shft.
  logic go_ld, go_st, go_sh, mis_trap;
  assign go_ld    = start_i & instr_ld_i;
  assign go_st    = start_i & ~instr_ld_i & instr_st_i;
  assign go_sh    = start_i & ~instr_ld_i & ~instr_st_i & shft_op_i;
  // Gated by rst_in so that a start held during reset cannot leak a trap.
  assign mis_trap = rst_in & (state == IDLE) & (go_ld | go_st) & misalngd_i;

  logic icyc_last;
  assign icyc_last = (icyc == ICYC_LAST);

  logic to_hit, to_trap;
`ifdef FAZYRV_SPMD_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] to_cnt;

  // The timeout fires on the last allowed WAIT cycle if that cycle still has no ack.
  assign to_hit = (state == WAIT) & ~dmem_ack_i & (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Count WAIT cycles. Register the timeout so the trap lands on the first idle cycle.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      to_cnt  <= '0;
      to_trap <= 1'b0;
    end else begin
      to_trap <= to_hit;
      to_cnt  <= ((state == WAIT) && !dmem_ack_i && !to_hit) ? to_cnt + 1'b1 : '0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_trap = 1'b0;
`endif

  // Main sequencer: dispatch, the chunk passes, the dmem wait and the shift phase.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      icyc  <= '0;
      op_ld <= 1'b0;
      op_st <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((go_ld | go_st) & misalngd_i) begin
            state <= IDLE;
          end else if (go_ld) begin
            op_ld <= 1'b1;
            op_st <= 1'b0;
            state <= WAIT;
          end else if (go_st) begin
            op_ld <= 1'b0;
            op_st <= 1'b1;
            state <= FILL;
          end else if (go_sh) begin
            op_ld <= 1'b0;
            op_st <= 1'b0;
            state <= FILL;
          end
        end
        FILL: begin
          if (icyc_last) begin
            icyc  <= '0;
            state <= op_st ? WAIT : SHFT;
          end else begin
            icyc  <= icyc + 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack_i)  state <= op_st ? IDLE : SHFT;
          else if (to_hit) state <= IDLE;
        end
        SHFT: begin
          if (shft_done_i) state <= DRAIN;
        end
        DRAIN: begin
          if (icyc_last) begin
            icyc  <= '0;
            state <= IDLE;
          end else begin
            icyc  <= icyc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Qualifiers decode straight from the state register. Only ld_par and the
  // store done depend on the ack, and both are forced low by the IDLE reset state.
  logic in_fill, in_wait, in_drain, in_pass;
  assign in_fill  = (state == FILL);
  assign in_wait  = (state == WAIT);
  assign in_drain = (state == DRAIN);
  assign in_pass  = in_fill | in_drain;

  assign dmem_stb_o = in_wait;
  assign dmem_we_o  = in_wait & op_st;
  assign cyc_wt_o   = in_wait;
  assign ld_par_o   = in_wait & op_ld & dmem_ack_i;
  assign cyc_rd_o   = in_drain;
  assign cyc_shft_o = (state == SHFT);
  assign icyc_o     = icyc;
  assign icyc_lsb_o = in_pass & (icyc == '0);
  assign icyc_msb_o = in_pass & icyc_last;
  assign busy_o     = (state != IDLE);
  assign done_o     = (in_wait & op_st & dmem_ack_i) | (in_drain & icyc_last);
  assign trap_o     = mis_trap | to_trap;

endmodule
